// File: rtl/uart_rx_dispatch.sv
// uart_rx_dispatch: parses header/length/payload frames from a UART receiver
// and steers payload bytes to one of four consumers over valid/ready.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   rx_data_i/valid_i  received byte and its one-cycle strobe
//   rx_err_i           framing error qualifier for the strobed byte
//   chan_en_i          per-channel enable (disabled frames are discarded)
//   ch_ready_i         per-channel consumer ready
//   ch_data_o          shared payload bus
//   ch_valid_o         one-hot payload valid
//   frame_done_o       pulse after the last byte of a frame is handed off
//   frame_drop_o       pulse when a disabled-channel frame completes
//   frame_chan_o       channel of the latest frame_done/frame_drop
//   err_*_o            single-cycle protocol error pulses
//   busy_o             parser mid-frame or hold register occupied
module uart_rx_dispatch #(
  parameter logic [5:0]  SYNC    = 6'b101010,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_err_i,
  input  logic [3:0] chan_en_i,
  input  logic [3:0] ch_ready_i,
  output logic [7:0] ch_data_o,
  output logic [3:0] ch_valid_o,
  output logic       frame_done_o,
  output logic [1:0] frame_chan_o,
  output logic       frame_drop_o,
  output logic       err_sync_o,
  output logic       err_len_o,
  output logic       err_frame_o,
  output logic       err_overrun_o,
  output logic       err_timeout_o,
  output logic       busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e         state_q;
  logic [1:0]     chan_q;
  logic [7:0]     cnt_q;
  logic [TW-1:0]  tmo_q;
  logic [3:0]     ch_valid_q;
  logic [7:0]     ch_data_q;
  logic [1:0]     hold_chan_q;
  logic           hold_last_q;
  logic           frame_done_q;
  logic           frame_drop_q;
  logic [1:0]     frame_chan_q;
  logic           err_sync_q;
  logic           err_len_q;
  logic           err_frame_q;
  logic           err_overrun_q;
  logic           err_timeout_q;

  logic hs;
  logic hdr_ok;
  logic len_ok;
  logic chan_on;
  logic last_byte;
  logic tmo_hit;

  // Handshake: the hold register is full exactly when a ch_valid bit is set,
  // and only the selected channel's ready can match it.
  always_comb begin
    hs        = |(ch_valid_q & ch_ready_i);
    hdr_ok    = (rx_data_i[7:2] == SYNC);
    len_ok    = (rx_data_i != 8'd0) && (32'(rx_data_i) <= MAX_LEN);
    chan_on   = chan_en_i[chan_q];
    last_byte = (cnt_q == 8'd1);
    tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
  end

  // Parser FSM, hold register and registered pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      chan_q        <= 2'd0;
      cnt_q         <= 8'd0;
      tmo_q         <= '0;
      ch_valid_q    <= 4'd0;
      ch_data_q     <= 8'd0;
      hold_chan_q   <= 2'd0;
      hold_last_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_drop_q  <= 1'b0;
      frame_chan_q  <= 2'd0;
      err_sync_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_drop_q  <= 1'b0;
      err_sync_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;

      // Consumer takes the pending entry; a new load below overrides the clear.
      if (hs) begin
        ch_valid_q  <= 4'd0;
        hold_last_q <= 1'b0;
        if (hold_last_q) begin
          frame_done_q <= 1'b1;
          frame_chan_q <= hold_chan_q;
        end
      end

      // Inter-byte idle counter, only meaningful inside a frame.
      if (state_q == ST_IDLE || rx_valid_i) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (rx_valid_i) begin
            if (rx_err_i) begin
              err_frame_q <= 1'b1;
            end else if (!hdr_ok) begin
              err_sync_q <= 1'b1;
            end else begin
              chan_q  <= rx_data_i[1:0];
              state_q <= ST_LEN;
            end
          end
        end

        ST_LEN: begin
          if (rx_valid_i) begin
            if (rx_err_i) begin
              err_frame_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else if (!len_ok) begin
              err_len_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              cnt_q   <= rx_data_i;
              state_q <= ST_PAYLOAD;
            end
          end else if (tmo_hit) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
            tmo_q         <= '0;
          end
        end

        ST_PAYLOAD: begin
          if (rx_valid_i) begin
            if (rx_err_i) begin
              err_frame_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else if (chan_on) begin
              if ((|ch_valid_q) && !hs) begin
                // Overrun aborts the frame; the pending entry stays but can
                // no longer complete a frame.
                err_overrun_q <= 1'b1;
                hold_last_q   <= 1'b0;
                state_q       <= ST_IDLE;
              end else begin
                ch_valid_q  <= 4'b0001 << chan_q;
                ch_data_q   <= rx_data_i;
                hold_chan_q <= chan_q;
                hold_last_q <= last_byte;
                cnt_q       <= cnt_q - 8'd1;
                if (last_byte) begin
                  state_q <= ST_IDLE;
                end
              end
            end else begin
              cnt_q <= cnt_q - 8'd1;
              if (last_byte) begin
                frame_drop_q <= 1'b1;
                frame_chan_q <= chan_q;
                state_q      <= ST_IDLE;
              end
            end
          end else if (tmo_hit) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
            tmo_q         <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ch_data_o     = ch_data_q;
  assign ch_valid_o    = ch_valid_q;
  assign frame_done_o  = frame_done_q;
  assign frame_drop_o  = frame_drop_q;
  assign frame_chan_o  = frame_chan_q;
  assign err_sync_o    = err_sync_q;
  assign err_len_o     = err_len_q;
  assign err_frame_o   = err_frame_q;
  assign err_overrun_o = err_overrun_q;
  assign err_timeout_o = err_timeout_q;
  assign busy_o        = (state_q != ST_IDLE) || (|ch_valid_q);

endmodule
